// File: rtl/mul_issue_sched.sv
// Issue queue for the pipelined multiply unit: captures operands from the CDB and
// issues the oldest ready uop (by ROB distance from head) over a valid/ready handshake.
package rv32i_types;
  localparam int ARCH_REG_IDX    = 4;
  localparam int PHYS_REG_IDX    = 5;
  localparam int NUM_ROB_ENTRIES = 32;
endpackage

module mul_issue_sched
  import rv32i_types::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int XLEN        = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic [$clog2(NUM_ROB_ENTRIES)-1:0] rob_head,
  input  logic                               disp_valid,
  output logic                               disp_ready,
  input  logic [2:0]                         disp_sub_op,
  input  logic [PHYS_REG_IDX:0]              disp_ps1,
  input  logic [PHYS_REG_IDX:0]              disp_ps2,
  input  logic                               disp_ps1_rdy,
  input  logic                               disp_ps2_rdy,
  input  logic [XLEN-1:0]                    disp_v1,
  input  logic [XLEN-1:0]                    disp_v2,
  input  logic [ARCH_REG_IDX:0]              disp_rd,
  input  logic [PHYS_REG_IDX:0]              disp_pd,
  input  logic [$clog2(NUM_ROB_ENTRIES)-1:0] disp_rob_idx,
  input  logic                               disp_dest_we,
  input  logic                               cdb_valid,
  input  logic [PHYS_REG_IDX:0]              cdb_pd,
  input  logic [XLEN-1:0]                    cdb_value,
  output logic                               iss_valid,
  input  logic                               iss_ready,
  output logic [XLEN-1:0]                    iss_op_a,
  output logic [XLEN-1:0]                    iss_op_b,
  output logic [2:0]                         iss_sub_op,
  output logic [ARCH_REG_IDX:0]              iss_rd,
  output logic [PHYS_REG_IDX:0]              iss_pd,
  output logic [$clog2(NUM_ROB_ENTRIES)-1:0] iss_rob_idx,
  output logic                               iss_dest_we,
  output logic [$clog2(NUM_ENTRIES):0]       free_count
);

  localparam int ROB_W = $clog2(NUM_ROB_ENTRIES);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  typedef struct packed {
    logic                    valid;
    logic [2:0]              sub_op;
    logic [PHYS_REG_IDX:0]   s1_tag;
    logic                    s1_rdy;
    logic [XLEN-1:0]         s1_val;
    logic [PHYS_REG_IDX:0]   s2_tag;
    logic                    s2_rdy;
    logic [XLEN-1:0]         s2_val;
    logic [ARCH_REG_IDX:0]   rd;
    logic [PHYS_REG_IDX:0]   pd;
    logic [ROB_W-1:0]        rob_idx;
    logic                    dest_we;
  } entry_t;

  entry_t           ent [NUM_ENTRIES];
  logic             elig [NUM_ENTRIES];
  logic [ROB_W-1:0] age [NUM_ENTRIES];

  logic [IDX_W-1:0] alloc_idx;
  logic [IDX_W-1:0] sel_idx;
  logic [ROB_W-1:0] sel_age;
  logic             sel_found;
  logic [CNT_W-1:0] free_cnt;
  logic             disp_fire;
  logic             issue_fire;
  logic             disp_s1_hit;
  logic             disp_s2_hit;

  // Free-entry count and lowest-index free slot, both from registered state only.
  always_comb begin
    free_cnt  = '0;
    alloc_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (!ent[i].valid) begin
        free_cnt  = free_cnt + CNT_W'(1);
        alloc_idx = IDX_W'(i);
      end
    end
  end

  assign free_count = free_cnt;
  assign disp_ready = (free_cnt != '0) && !flush;
  assign disp_fire  = disp_valid && disp_ready;

  // A dispatched operand that is not ready can still catch a broadcast in flight this cycle.
  assign disp_s1_hit = cdb_valid && !disp_ps1_rdy && (disp_ps1 == cdb_pd);
  assign disp_s2_hit = cdb_valid && !disp_ps2_rdy && (disp_ps2 == cdb_pd);

  // Oldest-first select; strict less-than keeps ties on the lowest index.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_age   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (elig[i] && (!sel_found || (age[i] < sel_age))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_age   = age[i];
      end
    end
  end

  assign iss_valid  = sel_found && !flush;
  assign issue_fire = iss_valid && iss_ready;

  always_comb begin
    iss_op_a    = '0;
    iss_op_b    = '0;
    iss_sub_op  = '0;
    iss_rd      = '0;
    iss_pd      = '0;
    iss_rob_idx = '0;
    iss_dest_we = 1'b0;
    if (iss_valid) begin
      iss_op_a    = ent[sel_idx].s1_val;
      iss_op_b    = ent[sel_idx].s2_val;
      iss_sub_op  = ent[sel_idx].sub_op;
      iss_rd      = ent[sel_idx].rd;
      iss_pd      = ent[sel_idx].pd;
      iss_rob_idx = ent[sel_idx].rob_idx;
      iss_dest_we = ent[sel_idx].dest_we;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_entry
      entry_t ent_reg;
      entry_t ent_next;
      logic   s1_wake;
      logic   s2_wake;

      assign s1_wake = cdb_valid && !ent_reg.s1_rdy && (ent_reg.s1_tag == cdb_pd);
      assign s2_wake = cdb_valid && !ent_reg.s2_rdy && (ent_reg.s2_tag == cdb_pd);

      always_comb begin
        ent_next = ent_reg;
        if (flush) begin
          ent_next.valid = 1'b0;
        end else if (disp_fire && (alloc_idx == IDX_W'(gi))) begin
          ent_next.valid   = 1'b1;
          ent_next.sub_op  = disp_sub_op;
          ent_next.s1_tag  = disp_ps1;
          ent_next.s1_rdy  = disp_ps1_rdy || disp_s1_hit;
          ent_next.s1_val  = disp_s1_hit ? cdb_value : disp_v1;
          ent_next.s2_tag  = disp_ps2;
          ent_next.s2_rdy  = disp_ps2_rdy || disp_s2_hit;
          ent_next.s2_val  = disp_s2_hit ? cdb_value : disp_v2;
          ent_next.rd      = disp_rd;
          ent_next.pd      = disp_pd;
          ent_next.rob_idx = disp_rob_idx;
          ent_next.dest_we = disp_dest_we;
        end else if (ent_reg.valid) begin
          if (s1_wake) begin
            ent_next.s1_rdy = 1'b1;
            ent_next.s1_val = cdb_value;
          end
          if (s2_wake) begin
            ent_next.s2_rdy = 1'b1;
            ent_next.s2_val = cdb_value;
          end
          if (issue_fire && (sel_idx == IDX_W'(gi))) begin
            ent_next.valid = 1'b0;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ent_reg <= '0;
        end else begin
          ent_reg <= ent_next;
        end
      end

      assign ent[gi]  = ent_reg;
      assign elig[gi] = ent_reg.valid && ent_reg.s1_rdy && ent_reg.s2_rdy;
      assign age[gi]  = ent_reg.rob_idx - rob_head;
    end
  endgenerate

endmodule

// File: tb/tb_mul_issue_sched.sv
// Scenario bench for mul_issue_sched: expected issues are queued when stimulus is
// driven and compared by a monitor whenever the handshake completes.
module tb_mul_issue_sched;
  logic        clk = 1'b0;
  logic        rst, flush;
  logic [4:0]  rob_head;
  logic        disp_valid, disp_ready;
  logic [2:0]  disp_sub_op;
  logic [5:0]  disp_ps1, disp_ps2;
  logic        disp_ps1_rdy, disp_ps2_rdy;
  logic [31:0] disp_v1, disp_v2;
  logic [4:0]  disp_rd;
  logic [5:0]  disp_pd;
  logic [4:0]  disp_rob_idx;
  logic        disp_dest_we;
  logic        cdb_valid;
  logic [5:0]  cdb_pd;
  logic [31:0] cdb_value;
  logic        iss_valid, iss_ready;
  logic [31:0] iss_op_a, iss_op_b;
  logic [2:0]  iss_sub_op;
  logic [4:0]  iss_rd;
  logic [5:0]  iss_pd;
  logic [4:0]  iss_rob_idx;
  logic        iss_dest_we;
  logic [2:0]  free_count;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [5:0]  pd;
    logic [4:0]  rob;
    logic        we;
  } exp_t;

  exp_t exp_q[$];
  int   vectors = 0;
  int   errors  = 0;

  mul_issue_sched #(.NUM_ENTRIES(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .rob_head(rob_head),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_sub_op(disp_sub_op),
    .disp_ps1(disp_ps1), .disp_ps2(disp_ps2), .disp_ps1_rdy(disp_ps1_rdy),
    .disp_ps2_rdy(disp_ps2_rdy), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_rd(disp_rd), .disp_pd(disp_pd), .disp_rob_idx(disp_rob_idx),
    .disp_dest_we(disp_dest_we), .cdb_valid(cdb_valid), .cdb_pd(cdb_pd),
    .cdb_value(cdb_value), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op_a(iss_op_a), .iss_op_b(iss_op_b), .iss_sub_op(iss_sub_op),
    .iss_rd(iss_rd), .iss_pd(iss_pd), .iss_rob_idx(iss_rob_idx),
    .iss_dest_we(iss_dest_we), .free_count(free_count)
  );

  always #5 clk = ~clk;

  // rd/pd/dest_we are derived from the ROB slot so each uop is distinguishable.
  function automatic exp_t mk_exp(input logic [31:0] a, input logic [31:0] b,
                                  input logic [2:0] op, input logic [4:0] rob);
    exp_t e;
    e.a = a; e.b = b; e.op = op; e.rob = rob;
    e.rd = rob; e.pd = {1'b1, rob}; e.we = rob[0];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic [2:0] op, input logic [5:0] ps1, input logic r1,
                          input logic [31:0] v1, input logic [5:0] ps2, input logic r2,
                          input logic [31:0] v2, input logic [4:0] rob);
    disp_valid = 1'b1; disp_sub_op = op;
    disp_ps1 = ps1; disp_ps1_rdy = r1; disp_v1 = v1;
    disp_ps2 = ps2; disp_ps2_rdy = r2; disp_v2 = v2;
    disp_rob_idx = rob; disp_rd = rob; disp_pd = {1'b1, rob}; disp_dest_we = rob[0];
  endtask

  task automatic dispatch(input logic [2:0] op, input logic [5:0] ps1, input logic r1,
                          input logic [31:0] v1, input logic [5:0] ps2, input logic r2,
                          input logic [31:0] v2, input logic [4:0] rob);
    set_disp(op, ps1, r1, v1, ps2, r2, v2, rob);
    tick();
    disp_valid = 1'b0;
  endtask

  // Handshake monitor: the issue captured here completes at the following edge.
  always @(negedge clk) begin
    if (!rst && iss_valid && iss_ready) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected rob=%0d a=%h b=%h", iss_rob_idx, iss_op_a, iss_op_b);
      end else begin
        exp_t e;
        exp_t got;
        e = exp_q.pop_front();
        got = '{a: iss_op_a, b: iss_op_b, op: iss_sub_op, rd: iss_rd, pd: iss_pd,
                rob: iss_rob_idx, we: iss_dest_we};
        if (got !== e) begin
          errors++;
          $display("FAIL issue_fields got a=%h b=%h op=%0d rob=%0d rd=%0d pd=%0d we=%0d exp a=%h b=%h op=%0d rob=%0d rd=%0d pd=%0d we=%0d",
                   got.a, got.b, got.op, got.rob, got.rd, got.pd, got.we,
                   e.a, e.b, e.op, e.rob, e.rd, e.pd, e.we);
        end else begin
          $display("issue rob=%0d op=%0d a=%h b=%h", got.rob, got.op, got.a, got.b);
        end
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; rob_head = '0; disp_valid = 1'b0; iss_ready = 1'b0;
    cdb_valid = 1'b0; cdb_pd = '0; cdb_value = '0;
    set_disp(3'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 5'd0);
    disp_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
    vectors++;
    if (disp_ready !== 1'b1 || free_count !== 3'd4 || iss_valid !== 1'b0 ||
        iss_op_a !== 32'd0 || iss_rob_idx !== 5'd0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b free=%0d iv=%b a=%h exp rdy=1 free=4 iv=0 a=0",
               disp_ready, free_count, iss_valid, iss_op_a);
    end
  endtask

  task automatic test_basic();
    dispatch(3'd0, 6'd1, 1'b1, 32'd3, 6'd2, 1'b1, 32'd5, 5'd0);
    vectors++;
    if (iss_valid !== 1'b1 || iss_op_a !== 32'd3 || iss_op_b !== 32'd5 ||
        iss_sub_op !== 3'd0 || free_count !== 3'd3) begin
      errors++;
      $display("FAIL basic_present got iv=%b a=%h b=%h op=%0d free=%0d exp 1 3 5 0 3",
               iss_valid, iss_op_a, iss_op_b, iss_sub_op, free_count);
    end
    exp_q.push_back(mk_exp(32'd3, 32'd5, 3'd0, 5'd0));
    iss_ready = 1'b1; tick(); iss_ready = 1'b0;
    vectors++;
    if (iss_valid !== 1'b0 || free_count !== 3'd4) begin
      errors++;
      $display("FAIL basic_drain got iv=%b free=%0d exp iv=0 free=4", iss_valid, free_count);
    end
  endtask

  task automatic test_wakeup();
    dispatch(3'd1, 6'd7, 1'b0, 32'hDEAD_0000, 6'd8, 1'b1, 32'd2, 5'd1);
    vectors++;
    if (iss_valid !== 1'b0) begin
      errors++;
      $display("FAIL wakeup_wait got iv=%b exp 0", iss_valid);
    end
    cdb_valid = 1'b1; cdb_pd = 6'd7; cdb_value = 32'hFFFF_FFFF;
    #1;
    vectors++;
    if (iss_valid !== 1'b0) begin
      errors++;
      $display("FAIL wakeup_no_bypass got iv=%b exp 0", iss_valid);
    end
    tick();
    cdb_value = 32'd123;
    tick();
    cdb_valid = 1'b0;
    vectors++;
    if (iss_valid !== 1'b1 || iss_op_a !== 32'hFFFF_FFFF || iss_sub_op !== 3'd1) begin
      errors++;
      $display("FAIL wakeup_capture got iv=%b a=%h op=%0d exp 1 ffffffff 1",
               iss_valid, iss_op_a, iss_sub_op);
    end
    exp_q.push_back(mk_exp(32'hFFFF_FFFF, 32'd2, 3'd1, 5'd1));
    iss_ready = 1'b1; tick(); iss_ready = 1'b0;
  endtask

  task automatic test_age_wrap();
    rob_head = 5'd30;
    dispatch(3'd3, 6'd0, 1'b1, 32'd11, 6'd0, 1'b1, 32'd12, 5'd1);
    dispatch(3'd2, 6'd0, 1'b1, 32'd21, 6'd0, 1'b1, 32'd22, 5'd31);
    vectors++;
    if (iss_valid !== 1'b1 || iss_rob_idx !== 5'd31) begin
      errors++;
      $display("FAIL age_wrap_select got iv=%b rob=%0d exp 1 31", iss_valid, iss_rob_idx);
    end
    exp_q.push_back(mk_exp(32'd21, 32'd22, 3'd2, 5'd31));
    exp_q.push_back(mk_exp(32'd11, 32'd12, 3'd3, 5'd1));
    iss_ready = 1'b1; tick(); tick(); iss_ready = 1'b0;
    rob_head = 5'd0;
    vectors++;
    if (free_count !== 3'd4) begin
      errors++;
      $display("FAIL age_wrap_drain got free=%0d exp 4", free_count);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++)
      dispatch(3'(i), 6'd0, 1'b1, 32'(100 + i), 6'd0, 1'b1, 32'(200 + i), 5'(2 + i));
    vectors++;
    if (free_count !== 3'd0 || disp_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state got free=%0d rdy=%b exp 0 0", free_count, disp_ready);
    end
    set_disp(3'd0, 6'd0, 1'b1, 32'd999, 6'd0, 1'b1, 32'd999, 5'd20);
    tick();
    vectors++;
    if (free_count !== 3'd0) begin
      errors++;
      $display("FAIL full_refuse got free=%0d exp 0", free_count);
    end
    exp_q.push_back(mk_exp(32'd100, 32'd200, 3'd0, 5'd2));
    iss_ready = 1'b1; tick(); iss_ready = 1'b0; disp_valid = 1'b0;
    vectors++;
    if (free_count !== 3'd1 || disp_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_one_free got free=%0d rdy=%b exp 1 1", free_count, disp_ready);
    end
    for (int i = 1; i < 4; i++)
      exp_q.push_back(mk_exp(32'(100 + i), 32'(200 + i), 3'(i), 5'(2 + i)));
    iss_ready = 1'b1; tick(); tick(); tick(); iss_ready = 1'b0;
    vectors++;
    if (free_count !== 3'd4 || iss_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_drain got free=%0d iv=%b exp 4 0", free_count, iss_valid);
    end
  endtask

  task automatic test_collision();
    set_disp(3'd0, 6'd9, 1'b0, 32'd0, 6'd10, 1'b1, 32'd6, 5'd7);
    cdb_valid = 1'b1; cdb_pd = 6'd9; cdb_value = 32'd42;
    tick();
    disp_valid = 1'b0; cdb_valid = 1'b0;
    vectors++;
    if (iss_valid !== 1'b1 || iss_op_a !== 32'd42 || iss_op_b !== 32'd6) begin
      errors++;
      $display("FAIL collision got iv=%b a=%0d b=%0d exp 1 42 6", iss_valid, iss_op_a, iss_op_b);
    end
    exp_q.push_back(mk_exp(32'd42, 32'd6, 3'd0, 5'd7));
    iss_ready = 1'b1; tick(); iss_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++)
      dispatch(3'd0, 6'd0, 1'b1, 32'(i), 6'd0, 1'b1, 32'(i), 5'(8 + i));
    flush = 1'b1; iss_ready = 1'b1;
    set_disp(3'd0, 6'd0, 1'b1, 32'd5, 6'd0, 1'b1, 32'd5, 5'd12);
    #1;
    vectors++;
    if (iss_valid !== 1'b0 || disp_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_gate got iv=%b rdy=%b exp 0 0", iss_valid, disp_ready);
    end
    tick();
    flush = 1'b0; disp_valid = 1'b0; iss_ready = 1'b0;
    vectors++;
    if (free_count !== 3'd4 || iss_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_clear got free=%0d iv=%b exp 4 0", free_count, iss_valid);
    end
  endtask

  task automatic test_midrun_reset();
    dispatch(3'd1, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 5'd3);
    dispatch(3'd1, 6'd4, 1'b0, 32'd1, 6'd0, 1'b1, 32'd1, 5'd4);
    rst = 1'b1; tick(); rst = 1'b0;
    vectors++;
    if (free_count !== 3'd4 || iss_valid !== 1'b0 || disp_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrun_reset got free=%0d iv=%b rdy=%b exp 4 0 1",
               free_count, iss_valid, disp_ready);
    end
  endtask

  task automatic test_back_to_back();
    iss_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      logic [31:0] a, b;
      a = $urandom; b = $urandom;
      exp_q.push_back(mk_exp(a, b, 3'(i % 4), 5'(10 + i)));
      dispatch(3'(i % 4), 6'd0, 1'b1, a, 6'd0, 1'b1, b, 5'(10 + i));
    end
    tick();
    iss_ready = 1'b0;
    vectors++;
    if (free_count !== 3'd4 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL back_to_back got free=%0d pending=%0d exp 4 0", free_count, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wakeup();
    test_age_wrap();
    test_full();
    test_collision();
    test_flush();
    test_midrun_reset();
    test_back_to_back();
    tick();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
